// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - Moore sequencer for a four-input Maxnet winner search.
// Steps the datapath through load, init, multiply, add and check phases until one activation survives.
module maxnet_controller #(
  parameter int MAX_ITER = 32,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              found,
  output logic              mainRegWrite,
  output logic              actWrite,
  output logic              multWrite,
  output logic              addWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_INIT   = 4'd2,
    S_MULT   = 4'd3,
    S_ADD    = 4'd4,
    S_CHECK  = 4'd5,
    S_UPDATE = 4'd6,
    S_DONE   = 4'd7,
    S_FAIL   = 4'd8
  } state_t;

  localparam logic [ITER_W-1:0] C_MAX_ITER = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] C_SAT      = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [ITER_W-1:0] r_iter_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // abort wins over everything, including start while idle
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next_state = S_LOAD;
        S_LOAD:   w_next_state = S_INIT;
        S_INIT:   w_next_state = S_MULT;
        S_MULT:   w_next_state = S_ADD;
        S_ADD:    w_next_state = S_CHECK;
        S_CHECK: begin
          if (found)                             w_next_state = S_DONE;
          else if (r_iter_count == C_MAX_ITER)   w_next_state = S_FAIL;
          else                                   w_next_state = S_UPDATE;
        end
        S_UPDATE: w_next_state = S_MULT;
        S_DONE:   w_next_state = S_IDLE;
        S_FAIL:   w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // count is kept through DONE/FAIL/abort so software can read how far the search got
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter_count <= '0;
    end else if (!abort) begin
      if (r_state == S_LOAD) begin
        r_iter_count <= '0;
      end else if (r_state == S_ADD && r_iter_count != C_SAT) begin
        r_iter_count <= r_iter_count + 1'b1;
      end
    end
  end

  always_comb begin
    mainRegWrite = 1'b0;
    actWrite     = 1'b0;
    multWrite    = 1'b0;
    addWrite     = 1'b0;
    s1           = 1'b0;
    s2           = 1'b0;
    s3           = 1'b0;
    s4           = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    fail         = 1'b0;
    case (r_state)
      S_LOAD: begin
        mainRegWrite = 1'b1;
        busy         = 1'b1;
      end
      S_INIT: begin
        actWrite = 1'b1;
        busy     = 1'b1;
      end
      S_MULT: begin
        multWrite = 1'b1;
        busy      = 1'b1;
      end
      S_ADD: begin
        addWrite = 1'b1;
        busy     = 1'b1;
      end
      S_CHECK: begin
        busy = 1'b1;
      end
      S_UPDATE: begin
        actWrite = 1'b1;
        s1       = 1'b1;
        s2       = 1'b1;
        s3       = 1'b1;
        s4       = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_FAIL:  fail = 1'b1;
      default: ;
    endcase
  end

  assign iter_count = r_iter_count;

endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - self-checking bench for maxnet_controller.
// Expected traces are derived from cycle position arithmetic, not from a state machine copy.
module tb_maxnet_controller;

  localparam int MAXI = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       found;
  logic       mainRegWrite, actWrite, multWrite, addWrite;
  logic       s1, s2, s3, s4;
  logic       busy, done, fail;
  logic [7:0] iter_count;

  int n_pass;
  int n_total;

  maxnet_controller #(.MAX_ITER(MAXI), .ITER_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .found        (found),
    .mainRegWrite (mainRegWrite),
    .actWrite     (actWrite),
    .multWrite    (multWrite),
    .addWrite     (addWrite),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .s4           (s4),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .iter_count   (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mainRegWrite, actWrite, multWrite, addWrite, s1, s2, s3, s4, busy, done, fail}
  localparam logic [10:0] V_IDLE   = 11'b00000000000;
  localparam logic [10:0] V_LOAD   = 11'b10000000100;
  localparam logic [10:0] V_INIT   = 11'b01000000100;
  localparam logic [10:0] V_MULT   = 11'b00100000100;
  localparam logic [10:0] V_ADD    = 11'b00010000100;
  localparam logic [10:0] V_CHECK  = 11'b00000000100;
  localparam logic [10:0] V_UPDATE = 11'b01001111100;
  localparam logic [10:0] V_DONE   = 11'b00000000010;
  localparam logic [10:0] V_FAIL   = 11'b00000000001;

  logic [10:0] w_out;
  assign w_out = {mainRegWrite, actWrite, multWrite, addWrite, s1, s2, s3, s4, busy, done, fail};

  typedef struct {
    int k;
    bit fl;
    int done_c;
    int fail_c;
    int iter;
  } vec_t;

  vec_t tbl[4];

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle c counts edges after the start-sampling edge; k is the CHECK at which the search ends.
  function automatic logic [10:0] model_out(input int c, input int k, input bit fl);
    int e;
    e = 4 * k + 2;
    if (c == 1) return V_LOAD;
    if (c == 2) return V_INIT;
    if (c < e) begin
      case ((c - 3) % 4)
        0:       return V_MULT;
        1:       return V_ADD;
        2:       return V_CHECK;
        default: return V_UPDATE;
      endcase
    end
    if (c == e) return fl ? V_FAIL : V_DONE;
    return V_IDLE;
  endfunction

  function automatic int model_iter(input int c, input int k, input int prev);
    int n;
    if (c == 1) return prev;
    n = (c - 1) / 4;
    return (n < k) ? n : k;
  endfunction

  task automatic run_search(input int k, input bit fl, input bit noise,
                            output int done_c, output int fail_c, output int iter_o);
    int e;
    int prev;
    e      = 4 * k + 2;
    prev   = int'(iter_count);
    done_c = 0;
    fail_c = 0;
    abort  = 1'b0;
    found  = 1'b0;
    start  = 1'b1;
    tick();
    for (int c = 1; c <= e + 1; c++) begin
      ck($sformatf("trace c=%0d k=%0d", c, k), 32'(w_out), 32'(model_out(c, k, fl)));
      ck($sformatf("iter c=%0d k=%0d", c, k), 32'(iter_count), 32'(model_iter(c, k, prev)));
      if (done && done_c == 0) done_c = c;
      if (fail && fail_c == 0) fail_c = c;
      start = (noise && c <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c >= 5 && (c - 5) % 4 == 0 && c < e) found = (c == e - 1) && !fl;
      else found = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start  = 1'b0;
    found  = 1'b0;
    iter_o = int'(iter_count);
  endtask

  initial begin
    int dc, fc, it, k;
    bit fl;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    found   = 1'b1;

    tbl[0] = '{1, 1'b0, 6, 0, 1};
    tbl[1] = '{2, 1'b0, 10, 0, 2};
    tbl[2] = '{3, 1'b0, 14, 0, 3};
    tbl[3] = '{3, 1'b1, 0, 14, 3};

    #22;
    ck("reset outputs", 32'(w_out), 32'(V_IDLE));
    ck("reset iter", 32'(iter_count), 32'd0);
    start = 1'b0;
    found = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("post-reset idle", 32'(w_out), 32'(V_IDLE));
    end

    for (int i = 0; i < 4; i++) begin
      run_search(tbl[i].k, tbl[i].fl, 1'b0, dc, fc, it);
      ck($sformatf("tbl%0d done cycle", i), 32'(dc), 32'(tbl[i].done_c));
      ck($sformatf("tbl%0d fail cycle", i), 32'(fc), 32'(tbl[i].fail_c));
      ck($sformatf("tbl%0d iter", i), 32'(it), 32'(tbl[i].iter));
    end

    // abort during MULT of the second iteration
    found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    ck("abort at mult", 32'(w_out), 32'(V_MULT));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ck("abort idle", 32'(w_out), 32'(V_IDLE));
    ck("abort iter", 32'(iter_count), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      ck("abort quiet", 32'(w_out), 32'(V_IDLE));
    end

    // abort beats start while idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    ck("idle abort priority", 32'(w_out), 32'(V_IDLE));
    tick();
    ck("idle abort stays", 32'(w_out), 32'(V_IDLE));

    // asynchronous reset mid-ADD
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    ck("pre-reset add", 32'(w_out), 32'(V_ADD));
    #2;
    rst = 1'b0;
    #1;
    ck("async reset outputs", 32'(w_out), 32'(V_IDLE));
    ck("async reset iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("release idle", 32'(w_out), 32'(V_IDLE));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ck("restart load", 32'(w_out), 32'(V_LOAD));
    tick();
    ck("restart iter", 32'(iter_count), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // start held through a whole search, found stuck high
    start = 1'b1;
    found = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c <= 6) ck($sformatf("held c=%0d", c), 32'(w_out), 32'(model_out(c, 1, 1'b0)));
      else if (c == 7) ck("held reidle", 32'(w_out), 32'(V_IDLE));
      else ck("held relaunch", 32'(w_out), 32'(V_LOAD));
      if (c < 8) tick();
    end
    start = 1'b0;
    found = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // randomized searches with noise on start/found outside CHECK
    for (int i = 0; i < 24; i++) begin
      fl = 1'($urandom_range(0, 3) == 0);
      k  = fl ? MAXI : int'($urandom_range(1, MAXI));
      run_search(k, fl, 1'b1, dc, fc, it);
      ck($sformatf("rand%0d end", i), 32'(fl ? fc : dc), 32'(4 * k + 2));
      ck($sformatf("rand%0d iter", i), 32'(it), 32'(k));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 32, the maximum number of competition iterations before giving up (legal range 1..255).
REQ-002 The block SHALL have parameter ITER_W, default 8, the width of the iteration counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to run one Maxnet search on the presented num1..num4.
REQ-006 Port abort  input  1  synchronous cancel of the current search.
REQ-007 Port found  input  1  datapath flag: exactly one surviving positive activation.
REQ-008 Port mainRegWrite  output  1  load enable for the datapath input registers.
REQ-009 Port actWrite  output  1  load enable for the datapath activation registers.
REQ-010 Port multWrite  output  1  load enable for the datapath processing-unit product registers.
REQ-011 Port addWrite  output  1  load enable for the datapath post-activation registers.
REQ-012 Ports s1, s2, s3, s4  output  1 each  activation-mux selects: 0 = input registers, 1 = fed-back activations.
REQ-013 Port busy  output  1  high while a search is in progress.
REQ-014 Port done  output  1  one-cycle pulse: winner found, datapath max valid.
REQ-015 Port fail  output  1  one-cycle pulse: MAX_ITER reached without a winner.
REQ-016 Port iter_count  output  ITER_W  number of completed CHECK evaluations in the current or last search.

Function
REQ-017 The block SHALL be a Moore FSM with states IDLE, LOAD, INIT, MULT, ADD, CHECK, UPDATE, DONE, FAIL; all outputs except iter_count SHALL be decoded from the state only.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD; in any other state start SHALL be ignored.
REQ-019 LOAD SHALL assert mainRegWrite for one cycle, clear iter_count to 0, and move to INIT.
REQ-020 INIT SHALL assert actWrite with s1..s4=0 for one cycle, then move to MULT.
REQ-021 MULT SHALL assert multWrite for one cycle, then move to ADD.
REQ-022 ADD SHALL assert addWrite for one cycle, increment iter_count by 1 (saturating at 2^ITER_W-1), then move to CHECK.
REQ-023 In CHECK the FSM SHALL sample found: found=1 -> DONE; else iter_count==MAX_ITER -> FAIL; else -> UPDATE. found=1 SHALL take priority when both conditions hold.
REQ-024 UPDATE SHALL assert actWrite with s1..s4=1 for one cycle, then move to MULT.
REQ-025 DONE SHALL assert done for exactly one cycle; FAIL SHALL assert fail for exactly one cycle; both SHALL then return to IDLE.
REQ-026 s1..s4 SHALL be 1 only in UPDATE and 0 in every other state.
REQ-027 busy SHALL be 1 in LOAD, INIT, MULT, ADD, CHECK, UPDATE and 0 in IDLE, DONE, FAIL.
REQ-028 At most one of mainRegWrite, actWrite, multWrite, addWrite SHALL be high in any cycle.
REQ-029 found SHALL be ignored outside CHECK.
REQ-030 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with no done or fail pulse; iter_count SHALL hold its value.
REQ-031 In IDLE, abort=1 SHALL take priority over start, and the FSM SHALL stay in IDLE.
REQ-032 iter_count SHALL hold its final value after DONE or FAIL until the next LOAD.
REQ-033 Latency from the start-sampling edge to the done pulse SHALL be 6 cycles for a first-iteration win, plus 4 cycles for each additional iteration.

Reset
REQ-034 rst=0 SHALL force IDLE asynchronously, including mid-search.
REQ-035 While rst=0, all outputs SHALL be 0 and iter_count SHALL be 0.
REQ-036 After rst returns to 1, the FSM SHALL take no action until a start is sampled in IDLE.

Verification
REQ-037 Scenario: reset, then start pulse with found=1 throughout -> strobes LOAD, INIT, MULT, ADD at cycles 1-4; done=1 at cycle 6; iter_count=1; busy low at cycle 6.
REQ-038 Scenario: MAX_ITER=3, found=0 always -> exactly 3 addWrite pulses; s1..s4=1 during both UPDATE cycles; fail=1 at cycle 14; iter_count=3; no done pulse.
REQ-039 Scenario: found rises only at the second CHECK -> done at cycle 10; iter_count=2.
REQ-040 Scenario: abort=1 in MULT of iteration 2 -> IDLE next cycle; busy=0; no done or fail pulse; iter_count=1.
REQ-041 Scenario: rst=0 asserted during ADD -> all outputs 0 immediately; a start after release begins at LOAD with iter_count=0.
REQ-042 Scenario: start held high through a complete search -> second search begins only after the FSM re-enters IDLE; found pulses outside CHECK cause no state change.
